// File: rtl/alu_issue_seq.sv
// Serial issue sequencer in front of a 16-bit ALU: accepts one instruction at a time,
// reads operands from a local register file, drives the ALU and writes the result back.
module alu_issue_seq #(
   parameter int REG_CNT = 8,
   parameter int ALU_LAT = 1
) (
   input  logic                       CLK,
   input  logic                       RST_n,
   input  logic                       InstrValid,
   output logic                       InstrReady,
   input  logic [3:0]                 InstrOp,
   input  logic [$clog2(REG_CNT)-1:0] InstrRd,
   input  logic [$clog2(REG_CNT)-1:0] InstrRs1,
   input  logic [$clog2(REG_CNT)-1:0] InstrRs2,
   input  logic                       InstrUseImm,
   input  logic [15:0]                InstrImm,
   input  logic                       InstrSetF,
   input  logic                       InstrCinMode,
   output logic                       AluEn,
   output logic [15:0]                AluA,
   output logic [15:0]                AluB,
   output logic [3:0]                 AluOpCode,
   output logic                       AluCin,
   input  logic [15:0]                AluResult,
   input  logic                       AluZero,
   input  logic                       AluCarry,
   input  logic                       AluOverflow,
   input  logic                       AluNegative,
   output logic [3:0]                 Flags,
   output logic                       Busy,
   output logic                       Done,
   input  logic [$clog2(REG_CNT)-1:0] DbgAddr,
   output logic [15:0]                DbgData
);

   localparam int AW = $clog2(REG_CNT);
   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [3:0] OP_SUB = 4'd1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic [15:0]   rf_r [REG_CNT];
   logic [3:0]    flags_r;
   logic [AW-1:0] rd_r;
   logic          setf_r;
   logic          alu_en_r;
   logic [15:0]   alu_a_r;
   logic [15:0]   alu_b_r;
   logic [3:0]    alu_op_r;
   logic          alu_cin_r;
   logic          done_r;
   logic          ready_r;
   logic          busy_r;
   logic          accept_s;
   logic          wb_s;
   logic [15:0]   opa_s;
   logic [15:0]   opb_s;
   logic          cin_s;

   // Next-state decode: accept in IDLE, writeback when the latency countdown expires
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      wb_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (InstrValid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_r == {CW{1'b0}}) begin
               wb_s        = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Operand selection; r0 always reads as zero
   always_comb begin
      opa_s = 16'h0000;
      opb_s = 16'h0000;
      cin_s = 1'b0;
      if (InstrRs1 == {AW{1'b0}}) begin
         opa_s = 16'h0000;
      end else begin
         opa_s = rf_r[InstrRs1];
      end
      if (InstrUseImm) begin
         opb_s = InstrImm;
      end else if (InstrRs2 == {AW{1'b0}}) begin
         opb_s = 16'h0000;
      end else begin
         opb_s = rf_r[InstrRs2];
      end
      if (InstrCinMode) begin
         cin_s = flags_r[2];
      end else begin
         cin_s = (InstrOp == OP_SUB);
      end
   end

   // State, latency counter and handshake/status outputs
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CW{1'b0}};
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         alu_en_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         ready_r  <= (state_nxt_s == ST_IDLE);
         busy_r   <= (state_nxt_s != ST_IDLE);
         done_r   <= wb_s;
         alu_en_r <= accept_s;
         if (state_r == ST_ISSUE) begin
            cnt_r <= CW'(ALU_LAT - 1);
         end else if ((state_r == ST_WAIT) && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // ALU drive registers are loaded at accept and held until the next instruction
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         alu_a_r   <= 16'h0000;
         alu_b_r   <= 16'h0000;
         alu_op_r  <= 4'h0;
         alu_cin_r <= 1'b0;
         rd_r      <= {AW{1'b0}};
         setf_r    <= 1'b0;
      end else if (accept_s) begin
         alu_a_r   <= opa_s;
         alu_b_r   <= opb_s;
         alu_op_r  <= InstrOp;
         alu_cin_r <= cin_s;
         rd_r      <= InstrRd;
         setf_r    <= InstrSetF;
      end else begin
         alu_a_r   <= alu_a_r;
         alu_b_r   <= alu_b_r;
         alu_op_r  <= alu_op_r;
         alu_cin_r <= alu_cin_r;
         rd_r      <= rd_r;
         setf_r    <= setf_r;
      end
   end

   // Register file and flag writeback; writes to r0 are dropped but flags still update
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < REG_CNT; i++) begin
            rf_r[i] <= 16'h0000;
         end
         flags_r <= 4'h0;
      end else begin
         if (wb_s && (rd_r != {AW{1'b0}})) begin
            rf_r[rd_r] <= AluResult;
         end
         if (wb_s && setf_r) begin
            flags_r <= {AluZero, AluCarry, AluOverflow, AluNegative};
         end else begin
            flags_r <= flags_r;
         end
      end
   end

   assign InstrReady = ready_r;
   assign Busy       = busy_r;
   assign Done       = done_r;
   assign AluEn      = alu_en_r;
   assign AluA       = alu_a_r;
   assign AluB       = alu_b_r;
   assign AluOpCode  = alu_op_r;
   assign AluCin     = alu_cin_r;
   assign Flags      = flags_r;
   assign DbgData    = (DbgAddr == {AW{1'b0}}) ? 16'h0000 : rf_r[DbgAddr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: plays the ALU, keeps a transaction-level model of the register
// file/flags/timeline, and compares every cycle plus a few hand-computed results.
module tb_alu_issue_seq;

   localparam int REG_CNT = 8;
   localparam int ALU_LAT = 1;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;

   logic        CLK;
   logic        RST_n;
   logic        InstrValid;
   logic        InstrReady;
   logic [3:0]  InstrOp;
   logic [2:0]  InstrRd;
   logic [2:0]  InstrRs1;
   logic [2:0]  InstrRs2;
   logic        InstrUseImm;
   logic [15:0] InstrImm;
   logic        InstrSetF;
   logic        InstrCinMode;
   logic        AluEn;
   logic [15:0] AluA;
   logic [15:0] AluB;
   logic [3:0]  AluOpCode;
   logic        AluCin;
   logic [3:0]  Flags;
   logic        Busy;
   logic        Done;
   logic [2:0]  DbgAddr;
   logic [15:0] DbgData;
   logic [19:0] alu_out;

   int errors = 0;
   int checks = 0;

   alu_issue_seq #(.REG_CNT(REG_CNT), .ALU_LAT(ALU_LAT)) dut (
      .CLK(CLK), .RST_n(RST_n),
      .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOp(InstrOp),
      .InstrRd(InstrRd), .InstrRs1(InstrRs1), .InstrRs2(InstrRs2),
      .InstrUseImm(InstrUseImm), .InstrImm(InstrImm), .InstrSetF(InstrSetF),
      .InstrCinMode(InstrCinMode),
      .AluEn(AluEn), .AluA(AluA), .AluB(AluB), .AluOpCode(AluOpCode), .AluCin(AluCin),
      .AluResult(alu_out[15:0]), .AluZero(alu_out[19]), .AluCarry(alu_out[18]),
      .AluOverflow(alu_out[17]), .AluNegative(alu_out[16]),
      .Flags(Flags), .Busy(Busy), .Done(Done), .DbgAddr(DbgAddr), .DbgData(DbgData)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Returns {Z,C,V,N,result}; C is carry-out (no-borrow for SUB)
   function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
      logic [16:0] s;
      logic [15:0] r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + {16'h0000, cin};
            r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = a;
      endcase
      return {(r == 16'h0000), c, v, r[15], r};
   endfunction

   // ALU stand-in: result appears ALU_LAT=1 cycle after the enable edge
   always @(posedge CLK) begin
      if (AluEn) alu_out <= alu_f(AluOpCode, AluA, AluB, AluCin);
   end

   logic       dbg_pin_en = 1'b0;
   logic [2:0] dbg_pin = 3'd0;
   always @(posedge CLK) begin
      DbgAddr <= dbg_pin_en ? dbg_pin : 3'($urandom_range(0, 7));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: instruction timeline in edge numbers, register file and flags
   int          cyc = 0;
   bit          pend = 1'b0;
   int          acc_edge = -10;
   int          wb_edge = -10;
   int          done_edge = -10;
   logic [15:0] rf_m [REG_CNT];
   logic [3:0]  flags_m = 4'h0;
   logic [15:0] pa, pb;
   logic [3:0]  pop;
   logic        pcin;
   logic [19:0] pres;
   int          prd;
   logic        psetf;

   initial begin
      bit idle;
      for (int i = 0; i < REG_CNT; i++) rf_m[i] = 16'h0000;
      forever begin
         @(posedge CLK);
         cyc++;
         if (!RST_n) begin
            pend = 1'b0;
            done_edge = -10;
            flags_m = 4'h0;
            for (int i = 0; i < REG_CNT; i++) rf_m[i] = 16'h0000;
         end else begin
            idle = !pend;
            if (pend && cyc == wb_edge) begin
               if (prd != 0) rf_m[prd] = pres[15:0];
               if (psetf) flags_m = pres[19:16];
               pend = 1'b0;
               done_edge = cyc;
            end
            if (idle && InstrValid) begin
               pa   = rf_m[InstrRs1];
               pb   = InstrUseImm ? InstrImm : rf_m[InstrRs2];
               pop  = InstrOp;
               pcin = InstrCinMode ? flags_m[2] : (InstrOp == OP_SUB);
               pres = alu_f(pop, pa, pb, pcin);
               prd  = int'(InstrRd);
               psetf = InstrSetF;
               pend = 1'b1;
               acc_edge = cyc;
               wb_edge = cyc + ALU_LAT + 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST_n) begin
            check("rst_aluen", 32'(AluEn), 32'd0);
            check("rst_done", 32'(Done), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
            check("rst_flags", 32'(Flags), 32'd0);
            check("rst_alua", 32'(AluA), 32'd0);
            check("rst_alub", 32'(AluB), 32'd0);
            check("rst_aluop", 32'(AluOpCode), 32'd0);
            check("rst_alucin", 32'(AluCin), 32'd0);
            check("rst_dbg", 32'(DbgData), 32'd0);
         end else begin
            check("ready", 32'(InstrReady), 32'(!pend));
            check("busy", 32'(Busy), 32'(pend));
            check("aluen", 32'(AluEn), 32'(pend && cyc == acc_edge));
            check("done", 32'(Done), 32'(cyc == done_edge));
            check("flags", 32'(Flags), 32'(flags_m));
            check("dbgdata", 32'(DbgData), 32'(rf_m[DbgAddr]));
            if (pend) begin
               check("alua", 32'(AluA), 32'(pa));
               check("alub", 32'(AluB), 32'(pb));
               check("aluop", 32'(AluOpCode), 32'(pop));
               check("alucin", 32'(AluCin), 32'(pcin));
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                        input logic use_imm, input logic [15:0] imm, input logic setf,
                        input logic cinm, output int lat, output logic cin_seen);
      int guard = 0;
      while (!InstrReady && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      lat = -1;
      cin_seen = 1'b0;
      if (!InstrReady) begin
         check("ready_timeout", 32'(InstrReady), 32'd1);
         return;
      end
      InstrOp = op; InstrRd = 3'(rd); InstrRs1 = 3'(rs1); InstrRs2 = 3'(rs2);
      InstrUseImm = use_imm; InstrImm = imm; InstrSetF = setf; InstrCinMode = cinm;
      InstrValid = 1'b1;
      @(negedge CLK);
      InstrValid = 1'b0;
      cin_seen = AluCin;
      lat = 0;
      while (!Done && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic peek(input int addr, output logic [15:0] v);
      dbg_pin = 3'(addr);
      dbg_pin_en = 1'b1;
      @(negedge CLK);
      v = DbgData;
      dbg_pin_en = 1'b0;
   endtask

   initial begin
      int lat;
      logic cs;
      logic [15:0] v;
      int n_en, n_done;
      RST_n = 1'b0; InstrValid = 1'b0; InstrOp = 4'h0; InstrRd = 3'd0; InstrRs1 = 3'd0;
      InstrRs2 = 3'd0; InstrUseImm = 1'b0; InstrImm = 16'h0000; InstrSetF = 1'b0;
      InstrCinMode = 1'b0;
      repeat (3) @(posedge CLK);
      #2 RST_n = 1'b1;
      @(negedge CLK);
      check("t1_ready", 32'(InstrReady), 32'd1);
      check("t1_busy", 32'(Busy), 32'd0);
      check("t1_aluen", 32'(AluEn), 32'd0);
      check("t1_flags", 32'(Flags), 32'd0);
      for (int a = 0; a < REG_CNT; a++) begin
         peek(a, v);
         check("t1_rf_zero", 32'(v), 32'd0);
      end

      issue(OP_ADD, 1, 0, 0, 1'b1, 16'h7FFF, 1'b0, 1'b0, lat, cs);
      check("t2_lat_a", 32'(lat), 32'd2);
      issue(OP_ADD, 2, 0, 0, 1'b1, 16'h0001, 1'b0, 1'b0, lat, cs);
      check("t2_lat_b", 32'(lat), 32'd2);
      issue(OP_ADD, 3, 1, 2, 1'b0, 16'h0000, 1'b1, 1'b0, lat, cs);
      check("t2_lat_c", 32'(lat), 32'd2);
      peek(3, v);
      check("t2_r3", 32'(v), 32'h8000);
      check("t2_flags", 32'(Flags), 32'h3);

      issue(OP_ADD, 1, 0, 0, 1'b1, 16'hFFFF, 1'b0, 1'b0, lat, cs);
      issue(OP_ADD, 4, 1, 0, 1'b1, 16'h0001, 1'b1, 1'b0, lat, cs);
      peek(4, v);
      check("t3_r4", 32'(v), 32'h0);
      check("t3_flags", 32'(Flags), 32'hC);
      issue(OP_ADD, 5, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b1, lat, cs);
      check("t3_cin", 32'(cs), 32'd1);
      peek(5, v);
      check("t3_r5", 32'(v), 32'h1);

      issue(OP_ADD, 7, 0, 0, 1'b1, 16'h5678, 1'b0, 1'b0, lat, cs);
      issue(OP_SUB, 6, 7, 0, 1'b1, 16'h1234, 1'b1, 1'b0, lat, cs);
      check("t4_cin", 32'(cs), 32'd1);
      peek(6, v);
      check("t4_r6", 32'(v), 32'h4444);
      check("t4_flags", 32'(Flags), 32'h4);

      issue(OP_ADD, 0, 0, 0, 1'b1, 16'h1234, 1'b1, 1'b0, lat, cs);
      peek(0, v);
      check("t5_r0", 32'(v), 32'h0);
      check("t5_flags", 32'(Flags), 32'h0);
      issue(OP_SUB, 2, 0, 0, 1'b1, 16'h0001, 1'b0, 1'b0, lat, cs);
      peek(2, v);
      check("t5_r2", 32'(v), 32'hFFFF);
      check("t5_flags_kept", 32'(Flags), 32'h0);

      // Valid held high over three instruction slots: r1 = r1 + 1 three times
      InstrOp = OP_ADD; InstrRd = 3'd1; InstrRs1 = 3'd1; InstrUseImm = 1'b1;
      InstrImm = 16'h0001; InstrSetF = 1'b0; InstrCinMode = 1'b0;
      InstrValid = 1'b1;
      n_en = 0;
      n_done = 0;
      for (int i = 0; i < 3 * (ALU_LAT + 2); i++) begin
         @(negedge CLK);
         n_en += int'(AluEn);
         n_done += int'(Done);
      end
      InstrValid = 1'b0;
      check("t6_accepts", 32'(n_en), 32'd3);
      check("t6_dones", 32'(n_done), 32'd3);
      peek(1, v);
      check("t6_r1", 32'(v), 32'h0002);

      // Reset while waiting on the ALU
      InstrOp = OP_ADD; InstrRd = 3'd3; InstrRs1 = 3'd0; InstrImm = 16'h00AA;
      InstrValid = 1'b1;
      @(negedge CLK);
      InstrValid = 1'b0;
      @(posedge CLK);
      #2 RST_n = 1'b0;
      repeat (2) @(posedge CLK);
      #2 RST_n = 1'b1;
      n_done = 0;
      repeat (5) begin
         @(negedge CLK);
         n_done += int'(Done);
      end
      check("t6_abort_done", 32'(n_done), 32'd0);
      check("t6_abort_ready", 32'(InstrReady), 32'd1);
      peek(3, v);
      check("t6_abort_r3", 32'(v), 32'h0);

      for (int it = 0; it < 200; it++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, cs);
         check("rand_lat", 32'(lat), 32'(ALU_LAT + 1));
      end

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
Upstream sequencer for ALU_16bit. Accepts one instruction at a time over a valid/ready handshake and reads operands from a local register file. It drives the ALU operand/opcode/Cin/EN inputs, waits the ALU latency, then writes the result and flags back. This provides a minimal serial datapath around the ALU so instruction streams can run without a bench driving the ALU directly.

Parameters:
REG_CNT, 8, number of 16-bit registers (power of 2, >=2); AW = log2(REG_CNT).
ALU_LAT, 1, cycles from the edge that samples AluEn=1 until AluResult/flags are valid (>=1).

Ports:
CLK  in  1  clock, all state on rising edge.
RST_n  in  1  asynchronous active-low reset.
InstrValid  in  1  instruction present.
InstrReady  out  1  high only in IDLE.
InstrOp  in  4  alu_pkg opcode (OP_ADD..OP_PASS).
InstrRd  in  AW  destination register.
InstrRs1  in  AW  source A register.
InstrRs2  in  AW  source B register.
InstrUseImm  in  1  1: B operand = InstrImm.
InstrImm  in  16  immediate.
InstrSetF  in  1  1: update Flags on writeback.
InstrCinMode  in  1  0: Cin=0 (SUB forces 1); 1: Cin = stored C flag.
AluEn  out  1  ALU enable.
AluA  out  16  to ALU A.
AluB  out  16  to ALU B.
AluOpCode  out  4  to ALU OpCode.
AluCin  out  1  to ALU Cin.
AluResult  in  16  from ALU Result.
AluZero, AluCarry, AluOverflow, AluNegative  in  1 each  ALU flags.
Flags  out  4  stored {Z,C,V,N}.
Busy  out  1  state != IDLE.
Done  out  1  one-cycle pulse after writeback.
DbgAddr  in  AW  debug read address.
DbgData  out  16  combinational rf[DbgAddr] (0 for r0).

Behaviour:
- Reset (async, RST_n=0): state=IDLE, all rf=0, Flags=0, AluEn=0, AluA/AluB/AluOpCode=0, AluCin=0, Done=0, InstrReady=1 after release. Reset mid-operation aborts the instruction: no rf/Flags write, no Done.
- States: IDLE, ISSUE, WAIT.
- IDLE: InstrReady=1. On InstrValid&InstrReady edge, latch all Instr* fields; go to ISSUE. No accept in ISSUE/WAIT; InstrValid held high is ignored until IDLE (no double accept).
- ISSUE (1 cycle): AluEn=1; AluA=rf[rs1]; AluB=UseImm?Imm:rf[rs2]; AluOpCode=op; AluCin = CinMode ? Flags.C : (op==OP_SUB). Next: WAIT with cnt=ALU_LAT-1.
- WAIT: AluEn=0, operands held stable. When cnt==0: at that edge write AluResult to rf[rd] (discarded if rd==0) and, if SetF, load Flags={AluZero,AluCarry,AluOverflow,AluNegative}; go IDLE; Done=1 in the following (IDLE) cycle. Otherwise cnt--.
- Latency: accept edge -> Done high = ALU_LAT+1 cycles. Throughput is one instruction per ALU_LAT+2 cycles; back-to-back dependent instructions are hazard-free (serial).
- r0 reads as 0 on operand and Dbg paths; flags still update from an r0-destined op when SetF=1.
- Operands are read in ISSUE, so a register written by the previous instruction is seen.
- CinMode=1 uses Flags.C as stored at ISSUE (chained ADD/SUB).

Test Plan:
1. Reset with RST_n=0 for 3 cycles -> DbgData=0 for all addresses, Flags=0, AluEn=0, InstrReady=1, Busy=0.
2. Load r1=r0+0x7FFF and r2=r0+0x0001 (imm), then r3=r1+r2 with SetF -> r3=0x8000, Flags Z=0 C=0 V=1 N=1; Done exactly 2 cycles after each accept edge (ALU_LAT=1).
3. r1=0xFFFF, then r4=r1+imm 0x0001 with SetF -> r4=0, Z=1 C=1; then ADD r5=r0+r0 with CinMode=1 -> AluCin=1, r5=0x0001.
4. SUB r6 = 0x5678 - 0x1234 with CinMode=0, SetF -> AluCin=1, r6=0x4444, C=1, Z=0, N=0.
5. ADD r0=r0+0x1234 with SetF -> DbgData(r0)=0, Flags Z=0 N=0; SetF=0 on the next op -> Flags unchanged.
6. InstrValid held high across 3 instructions -> exactly 3 accepts and 3 Done pulses. Then RST_n pulsed low during WAIT -> no rf write, no Done, InstrReady=1 after release.
